usb_packet_decoder: RTL and testbench

//  Receive-side packet decoder; counterpart of the transmit bitstream encoder. Consumes the

---
 rtl/usb_pkg.sv | 16 +
 rtl/crc16_serial.sv | 18 +
 rtl/usb_packet_decoder.sv | 119 +++++++++++
 tb/tb_usb_packet_decoder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// usb_pkg: shared USB PID codes, SYNC/CRC16 constants and receive-decoder state encoding.
package usb_pkg;
    typedef enum logic [3:0] {
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011
    } pid_t;
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_DATA, S_HSEOP, S_DEOP, S_DRAIN} state_t;
    localparam logic [7:0]  SYNC_BYTE  = 8'h80;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    function automatic logic pid_ok(input logic [7:0] b);
        return b[7:4] == ~b[3:0];
    endfunction
endpackage

// File: rtl/crc16_serial.sv
// crc16_serial: bit-serial CRC16 LFSR (x^16+x^15+x^2+1), shared by the transmit and receive paths.
module crc16_serial
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_L,
    input  logic        clear,
    input  logic        en,
    input  logic        inb,
    output logic [15:0] crc
);
    logic [15:0] crc_q;
    always_ff @(posedge clk) begin
        if (!rst_L || clear) crc_q <= CRC16_INIT;
        else if (en) crc_q <= {crc_q[14:0], 1'b0} ^ ({16{inb ^ crc_q[15]}} & CRC16_POLY);
    end
    assign crc = crc_q;
endmodule

// File: rtl/usb_packet_decoder.sv
// usb_packet_decoder: receive-side USB packet decoder; checks SYNC, PID and CRC16 and
// reports DATA0/DATA1 payloads and ACK/NAK handshakes as registered one-cycle pulses.
module usb_packet_decoder
    import usb_pkg::*;
#(
    parameter int          DATA_BITS      = 64,
    parameter logic [15:0] CRC16_RESIDUAL = 16'h800D
) (
    input  logic                 clk,
    input  logic                 rst_L,
    input  logic                 bit_valid,
    input  logic                 inb,
    input  logic                 eop,
    output logic [3:0]           pid,
    output logic [DATA_BITS-1:0] data,
    output logic                 pktready,
    output logic                 haveack,
    output logic                 havenak,
    output logic                 error
);
    localparam logic [6:0] LAST_BIT = 7'(DATA_BITS + 15);
    state_t               state_q;
    logic [6:0]           cnt_q;
    logic [6:0]           sh_q;
    logic [3:0]           cur_pid_q, pid_q;
    logic [DATA_BITS-1:0] shadow_q, data_q;
    logic                 pktready_q, haveack_q, havenak_q, error_q;
    logic [7:0]           byte_d;
    logic [15:0]          crc;
    assign byte_d = {inb, sh_q};
    crc16_serial u_crc (
        .clk   (clk),
        .rst_L (rst_L),
        .clear (state_q == S_PID),
        .en    (state_q == S_DATA && bit_valid && !eop),
        .inb   (inb),
        .crc   (crc)
    );
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            cur_pid_q  <= '0;
            pid_q      <= '0;
            shadow_q   <= '0;
            data_q     <= '0;
            pktready_q <= 1'b0;
            haveack_q  <= 1'b0;
            havenak_q  <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            pktready_q <= 1'b0;
            haveack_q  <= 1'b0;
            havenak_q  <= 1'b0;
            error_q    <= 1'b0;
            if (eop) begin
                // eop wins over a coincident bit; every non-idle state closes out here
                state_q <= S_IDLE;
                cnt_q   <= '0;
                if (state_q inside {S_SYNC, S_PID, S_DATA}) error_q <= 1'b1;
                if (state_q == S_HSEOP) begin
                    haveack_q <= cur_pid_q == PID_ACK;
                    havenak_q <= cur_pid_q == PID_NAK;
                    pid_q     <= cur_pid_q;
                end
                if (state_q == S_DEOP) begin
                    if (crc == CRC16_RESIDUAL) begin
                        pktready_q <= 1'b1;
                        data_q     <= shadow_q;
                        pid_q      <= cur_pid_q;
                    end else error_q <= 1'b1;
                end
            end else if (bit_valid) begin
                sh_q  <= byte_d[7:1];
                cnt_q <= cnt_q + 7'd1;
                case (state_q)
                    S_IDLE: state_q <= S_SYNC;
                    S_SYNC: if (cnt_q == 7'd7) begin
                        cnt_q   <= '0;
                        state_q <= byte_d == SYNC_BYTE ? S_PID : S_DRAIN;
                        error_q <= byte_d != SYNC_BYTE;
                    end
                    S_PID: if (cnt_q == 7'd7) begin
                        cnt_q     <= '0;
                        cur_pid_q <= byte_d[3:0];
                        if (pid_ok(byte_d) && (byte_d[3:0] == PID_ACK || byte_d[3:0] == PID_NAK))
                            state_q <= S_HSEOP;
                        else if (pid_ok(byte_d) && (byte_d[3:0] == PID_DATA0 || byte_d[3:0] == PID_DATA1))
                            state_q <= S_DATA;
                        else begin
                            state_q <= S_DRAIN;
                            error_q <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (cnt_q < 7'(DATA_BITS)) shadow_q <= {inb, shadow_q[DATA_BITS-1:1]};
                        if (cnt_q == LAST_BIT) begin
                            cnt_q   <= '0;
                            state_q <= S_DEOP;
                        end
                    end
                    S_HSEOP, S_DEOP: begin
                        cnt_q   <= '0;
                        state_q <= S_DRAIN;
                        error_q <= 1'b1;
                    end
                    default: cnt_q <= cnt_q;
                endcase
            end
        end
    end
    assign pid      = pid_q;
    assign data     = data_q;
    assign pktready = pktready_q;
    assign haveack  = haveack_q;
    assign havenak  = havenak_q;
    assign error    = error_q;
endmodule

// File: tb/tb_usb_packet_decoder.sv
// tb_usb_packet_decoder: directed and randomized packets with stuffing gaps, checked against a packet-level model.
module tb_usb_packet_decoder;
    logic        clk = 1'b0, rst_L = 1'b0, bit_valid = 1'b0, inb = 1'b0, eop = 1'b0;
    logic [3:0]  pid;
    logic [63:0] data;
    logic        pktready, haveack, havenak, error;
    int n_cmp = 0, n_err = 0;
    int c_rdy = 0, c_ack = 0, c_nak = 0, c_err = 0, c_multi = 0;
    bit          pkt[$];
    logic [3:0]  exp_pid = '0;
    logic [63:0] exp_data = '0;
    typedef enum int {K_NONE, K_ACK, K_NAK, K_DATA, K_ERR} kind_e;

    always #5 clk = ~clk;

    usb_packet_decoder dut (
        .clk(clk), .rst_L(rst_L), .bit_valid(bit_valid), .inb(inb), .eop(eop),
        .pid(pid), .data(data), .pktready(pktready), .haveack(haveack),
        .havenak(havenak), .error(error)
    );

    always @(negedge clk) begin
        c_rdy += int'(pktready);
        c_ack += int'(haveack);
        c_nak += int'(havenak);
        c_err += int'(error);
        if (int'(pktready) + int'(haveack) + int'(havenak) + int'(error) > 1) c_multi++;
    end

    function automatic logic [15:0] crc_of(input logic [63:0] p);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < 64; i++) c = {c[14:0], 1'b0} ^ ((p[i] ^ c[15]) ? 16'h8005 : 16'h0000);
        return c;
    endfunction

    function automatic void add_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) pkt.push_back(v[i]);
    endfunction

    function automatic void add_data(input logic [63:0] p, input bit flip, input int idx);
        logic [15:0] c = crc_of(p);
        for (int i = 0; i < 64; i++) pkt.push_back(p[i]);
        for (int i = 0; i < 16; i++) pkt.push_back(~c[15-i] ^ (flip && i == idx));
    endfunction

    function automatic void add_rand(input int n);
        for (int i = 0; i < n; i++) pkt.push_back(1'($urandom));
    endfunction

    // outcome of a whole packet, from the bit list alone
    function automatic kind_e classify(output logic [3:0] p_o, output logic [63:0] pay);
        int n = pkt.size();
        logic [7:0] s = '0, p = '0;
        logic [15:0] c;
        p_o = '0;
        pay = '0;
        if (n == 0) return K_NONE;
        if (n < 16) return K_ERR;
        for (int i = 0; i < 8; i++) begin
            s[i] = pkt[i];
            p[i] = pkt[8+i];
        end
        if (s != 8'h80 || p[7:4] != ~p[3:0]) return K_ERR;
        p_o = p[3:0];
        if (p[3:0] == 4'h2 || p[3:0] == 4'hA) return n != 16 ? K_ERR : (p[3:0] == 4'h2 ? K_ACK : K_NAK);
        if ((p[3:0] != 4'h3 && p[3:0] != 4'hB) || n != 96) return K_ERR;
        for (int i = 0; i < 64; i++) pay[i] = pkt[16+i];
        c = crc_of(pay);
        for (int i = 0; i < 16; i++) if (pkt[80+i] == c[15-i]) return K_ERR;
        return K_DATA;
    endfunction

    task automatic idle_cycle();
        @(negedge clk);
        bit_valid = 1'b0;
        eop = 1'b0;
        inb = 1'($urandom);
    endtask

    task automatic drive_bits(input bit nogap);
        foreach (pkt[i]) begin
            repeat ((i == 0 && nogap) ? 0 : $urandom_range(0, 2)) idle_cycle();
            @(negedge clk);
            bit_valid = 1'b1;
            inb = pkt[i];
            eop = 1'b0;
        end
    endtask

    task automatic drive_eop();
        repeat ($urandom_range(0, 2)) idle_cycle();
        @(negedge clk);
        eop = 1'b1;
        bit_valid = 1'($urandom);
        inb = 1'($urandom);
    endtask

    task automatic check_counts(input string name, input int s[4], input int e[4]);
        int g[4];
        g = '{c_rdy - s[0], c_ack - s[1], c_nak - s[2], c_err - s[3]};
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (g[i] !== e[i]) begin
                n_err++;
                $display("FAIL %s pulse_count[%0d]: got %0d expected %0d", name, i, g[i], e[i]);
            end
        end
        n_cmp++;
        if (c_multi !== 0) begin
            n_err++;
            $display("FAIL %s overlap: got %0d expected 0", name, c_multi);
        end
        n_cmp++;
        if (pid !== exp_pid) begin
            n_err++;
            $display("FAIL %s pid: got %0h expected %0h", name, pid, exp_pid);
        end
        n_cmp++;
        if (data !== exp_data) begin
            n_err++;
            $display("FAIL %s data: got %0h expected %0h", name, data, exp_data);
        end
    endtask

    task automatic run_pkt(input string name);
        kind_e k;
        logic [3:0] p;
        logic [63:0] pay;
        int s[4];
        logic obs;
        k = classify(p, pay);
        s = '{c_rdy, c_ack, c_nak, c_err};
        drive_bits(1'b0);
        drive_eop();
        idle_cycle();
        if (k inside {K_ACK, K_NAK, K_DATA}) begin
            obs = k == K_ACK ? haveack : k == K_NAK ? havenak : pktready;
            n_cmp++;
            if (obs !== 1'b1) begin
                n_err++;
                $display("FAIL %s pulse_timing: got %b expected 1", name, obs);
            end
            exp_pid = p;
            if (k == K_DATA) exp_data = pay;
        end
        idle_cycle();
        n_cmp++;
        if ({pktready, haveack, havenak, error} !== 4'b0) begin
            n_err++;
            $display("FAIL %s pulse_width: got %b expected 0000", name, {pktready, haveack, havenak, error});
        end
        repeat (2) idle_cycle();
        check_counts(name, s, '{int'(k == K_DATA), int'(k == K_ACK), int'(k == K_NAK), int'(k == K_ERR)});
    endtask

    task automatic test_reset();
        rst_L = 1'b0;
        repeat (3) idle_cycle();
        n_cmp++;
        if ({pid, data, pktready, haveack, havenak, error} !== '0) begin
            n_err++;
            $display("FAIL reset outputs: got pid=%0h data=%0h pulses=%b expected all 0", pid, data,
                     {pktready, haveack, havenak, error});
        end
        rst_L = 1'b1;
        idle_cycle();
    endtask

    task automatic test_ack();
        pkt = {};
        add_byte(8'h80);
        add_byte(8'hD2);
        run_pkt("ack");
    endtask

    task automatic test_data0();
        pkt = {};
        add_byte(8'h80);
        add_byte(8'hC3);
        add_data(64'h0123_4567_89AB_CDEF, 1'b0, 0);
        run_pkt("data0");
    endtask

    task automatic test_crc_err();
        pkt = {};
        add_byte(8'h80);
        add_byte(8'hC3);
        add_data(64'hFEDC_BA98_7654_3210, 1'b1, $urandom_range(0, 15));
        run_pkt("crc_err");
    endtask

    task automatic test_pid_mismatch();
        pkt = {};
        add_byte(8'h80);
        add_byte(8'hD3);
        add_rand(20);
        run_pkt("pid_mismatch");
        test_ack();
    endtask

    task automatic test_eop_idle();
        pkt = {};
        run_pkt("eop_idle");
    endtask

    task automatic test_back_to_back();
        int s[4];
        s = '{c_rdy, c_ack, c_nak, c_err};
        pkt = {};
        add_byte(8'h80);
        add_byte(8'hC3);
        add_rand(40);
        drive_bits(1'b0);
        drive_eop();
        pkt = {};
        add_byte(8'h80);
        add_byte(8'h5A);
        drive_bits(1'b1);
        drive_eop();
        idle_cycle();
        exp_pid = 4'hA;
        n_cmp++;
        if (havenak !== 1'b1) begin
            n_err++;
            $display("FAIL back_to_back nak_timing: got %b expected 1", havenak);
        end
        repeat (3) idle_cycle();
        check_counts("back_to_back", s, '{0, 0, 1, 1});
    endtask

    task automatic test_reset_mid();
        int s[4];
        s = '{c_rdy, c_ack, c_nak, c_err};
        pkt = {};
        add_byte(8'h80);
        add_byte(8'h4B);
        add_rand(30);
        drive_bits(1'b0);
        @(negedge clk);
        rst_L = 1'b0;
        bit_valid = 1'b0;
        @(negedge clk);
        rst_L = 1'b1;
        drive_eop();
        repeat (3) idle_cycle();
        exp_pid = '0;
        exp_data = '0;
        check_counts("reset_mid", s, '{0, 0, 0, 0});
        pkt = {};
        add_byte(8'h80);
        add_byte(8'h4B);
        add_data({$urandom, $urandom}, 1'b0, 0);
        run_pkt("data1_after_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            pkt = {};
            case ($urandom_range(0, 7))
                0: begin add_byte(8'h80); add_byte(8'hD2); end
                1: begin add_byte(8'h80); add_byte(8'h5A); end
                2: begin add_byte(8'h80); add_byte(8'hC3); add_data({$urandom, $urandom}, 1'b0, 0); end
                3: begin add_byte(8'h80); add_byte(8'h4B); add_data({$urandom, $urandom}, 1'b1, $urandom_range(0, 15)); end
                4: add_rand($urandom_range(1, 30));
                5: begin add_byte(8'h80); add_byte(8'($urandom)); add_rand($urandom_range(0, 96)); end
                6: begin
                    add_byte(8'h80); add_byte(8'h4B); add_data({$urandom, $urandom}, 1'b0, 0);
                    repeat ($urandom_range(1, 90)) void'(pkt.pop_back());
                end
                default: begin add_byte(8'h80); add_byte(8'hD2); add_rand($urandom_range(1, 3)); end
            endcase
            run_pkt("random");
        end
    endtask

    initial begin
        test_reset();
        test_ack();
        test_data0();
        test_crc_err();
        test_pid_mismatch();
        test_eop_idle();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
